// File: rtl/i2s_transmitter_pkg.sv
// Audio-path constants and sample typedefs shared by the I2S transmitter, receiver and effect controller.
package i2s_transmitter_pkg;
  localparam int AUDIO_D_WIDTH  = 24;
  localparam int I2S_SLOT_WIDTH = 32;
  localparam int I2S_SCLK_HALF  = 4;

  typedef logic [AUDIO_D_WIDTH-1:0] audio_sample_t;

  typedef struct packed {
    audio_sample_t l;
    audio_sample_t r;
  } audio_pair_t;
endpackage

// File: rtl/i2s_transmitter_clk_gen.sv
// I2S master timing: SCLK divider, bit counter within the stereo frame, LRCK and the
// strobes that tell the datapath where the next SCLK fall lands in the frame.
module i2s_transmitter_clk_gen
  import i2s_transmitter_pkg::*;
#(
  parameter int  slot_width = I2S_SLOT_WIDTH,
  parameter int  sclk_half  = I2S_SCLK_HALF,
  localparam int BW         = $clog2(2*slot_width)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          o_sclk,
  output logic          o_lrck,
  output logic          sclk_fall,
  output logic          frame_start,
  output logic          next_right,
  output logic [BW-1:0] next_pos
);
  localparam int             DIVW     = $clog2(sclk_half);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(sclk_half - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(2*slot_width - 1);
  localparam logic [BW-1:0]   SLOT_W   = BW'(slot_width);

  logic [DIVW-1:0] div_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [BW-1:0]   bit_nxt;

  // next_* describe the bit position that becomes current on this fall
  assign sclk_fall   = (div_cnt == DIV_LAST) && o_sclk;
  assign frame_start = sclk_fall && (bit_cnt == BIT_LAST);
  assign bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
  assign next_right  = (bit_nxt >= SLOT_W);
  assign next_pos    = next_right ? bit_nxt - SLOT_W : bit_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      o_sclk  <= 1'b0;
      bit_cnt <= BIT_LAST;
      o_lrck  <= 1'b1;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        o_sclk  <= ~o_sclk;
      end else begin
        div_cnt <= div_cnt + DIVW'(1);
      end
      if (sclk_fall) begin
        bit_cnt <= bit_nxt;
        o_lrck  <= next_right;
      end
    end
  end
endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: one-deep holding register with valid/ready, MSB-first serializer.
// Build option MUTE_ON_UNDERRUN_EN: an underrun frame sends zeros instead of repeating the last pair.
module i2s_transmitter
  import i2s_transmitter_pkg::*;
#(
  parameter int d_width    = AUDIO_D_WIDTH,
  parameter int slot_width = I2S_SLOT_WIDTH,
  parameter int sclk_half  = I2S_SCLK_HALF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [d_width-1:0] i_l_data,
  input  logic [d_width-1:0] i_r_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_sclk,
  output logic               o_lrck,
  output logic               o_sd,
  output logic               o_frame_start,
  output logic               o_underrun
);
  localparam int            BW        = $clog2(2*slot_width);
  localparam logic [BW-1:0] POS_LAST  = BW'(d_width);

  logic               sclk_fall;
  logic               frame_start;
  logic               next_right;
  logic [BW-1:0]      next_pos;
  logic               hold_full;
  logic               accept;
  logic               data_slot;
  logic [d_width-1:0] hold_l, hold_r;
  logic [d_width-1:0] shift_l, shift_r;
`ifndef MUTE_ON_UNDERRUN_EN
  logic [d_width-1:0] last_l, last_r;
`endif

  assign o_ready   = reset && !hold_full;
  assign accept    = i_valid && o_ready;
  // position 0 is the I2S one-bit delay, positions past d_width are padding
  assign data_slot = (next_pos != '0) && (next_pos <= POS_LAST);

  i2s_transmitter_clk_gen #(
    .slot_width (slot_width),
    .sclk_half  (sclk_half)
  ) u_clk_gen (
    .clk         (clk),
    .reset       (reset),
    .o_sclk      (o_sclk),
    .o_lrck      (o_lrck),
    .sclk_fall   (sclk_fall),
    .frame_start (frame_start),
    .next_right  (next_right),
    .next_pos    (next_pos)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_full     <= 1'b0;
      hold_l        <= '0;
      hold_r        <= '0;
      shift_l       <= '0;
      shift_r       <= '0;
`ifndef MUTE_ON_UNDERRUN_EN
      last_l        <= '0;
      last_r        <= '0;
`endif
      o_sd          <= 1'b0;
      o_frame_start <= 1'b0;
      o_underrun    <= 1'b0;
    end else begin
      o_frame_start <= 1'b0;
      o_underrun    <= 1'b0;
      // accept only happens while empty, so it never collides with the load below
      if (accept) begin
        hold_l    <= i_l_data;
        hold_r    <= i_r_data;
        hold_full <= 1'b1;
      end else if (frame_start && hold_full) begin
        hold_full <= 1'b0;
      end
      if (frame_start) begin
        o_frame_start <= 1'b1;
        o_sd          <= 1'b0;
        if (hold_full) begin
          shift_l <= hold_l;
          shift_r <= hold_r;
`ifndef MUTE_ON_UNDERRUN_EN
          last_l  <= hold_l;
          last_r  <= hold_r;
`endif
        end else begin
          o_underrun <= 1'b1;
`ifdef MUTE_ON_UNDERRUN_EN
          shift_l    <= '0;
          shift_r    <= '0;
`else
          shift_l    <= last_l;
          shift_r    <= last_r;
`endif
        end
      end else if (sclk_fall) begin
        if (!data_slot) begin
          o_sd <= 1'b0;
        end else if (next_right) begin
          o_sd    <= shift_r[d_width-1];
          shift_r <= {shift_r[d_width-2:0], 1'b0};
        end else begin
          o_sd    <= shift_l[d_width-1];
          shift_l <= {shift_l[d_width-2:0], 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter: frame-level reference model plus an I2S decoder on the bus pins.
module tb_i2s_transmitter;
  localparam int DW      = 24;
  localparam int SW      = 32;
  localparam int SH      = 4;
  localparam int SCLK_P  = 2*SH;
  localparam int FRAME_P = 2*SW*SCLK_P;
`ifdef MUTE_ON_UNDERRUN_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] i_l_data = '0;
  logic [DW-1:0] i_r_data = '0;
  logic          i_valid = 1'b0;
  logic          o_ready, o_sclk, o_lrck, o_sd, o_frame_start, o_underrun;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  i2s_transmitter #(.d_width(DW), .slot_width(SW), .sclk_half(SH)) dut (
    .clk(clk), .reset(reset), .i_l_data(i_l_data), .i_r_data(i_r_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_sclk(o_sclk), .o_lrck(o_lrck), .o_sd(o_sd),
    .o_frame_start(o_frame_start), .o_underrun(o_underrun)
  );

  // reference model: expected pin state after posedge number cyc since reset release
  int              cyc = 0;
  logic            m_full = 1'b0;
  logic [2*DW-1:0] m_hold = '0, m_last = '0;
  logic            exp_sclk = 1'b0, exp_lrck = 1'b1, exp_fs = 1'b0, exp_ur = 1'b0;
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] dec_q[$];
  int              mon_err = 0, ur_cnt = 0, acc_cnt = 0, pad_err = 0;
  logic            prev_sclk = 1'b0, prev_lrck = 1'b1;
  int              sb = 1000;
  logic [DW-1:0]   cur_l = '0, cur_r = '0;

  always @(negedge clk) begin
    int m, bit_i;
    if (o_sclk !== exp_sclk || o_lrck !== exp_lrck || o_frame_start !== exp_fs ||
        o_underrun !== exp_ur || o_ready !== (reset && !m_full)) begin
      mon_err++;
      if (mon_err <= 5)
        $display("[TB] pin check cyc=%0d sclk %b/%b lrck %b/%b fs %b/%b ur %b/%b rdy %b/%b", cyc,
                 o_sclk, exp_sclk, o_lrck, exp_lrck, o_frame_start, exp_fs, o_underrun, exp_ur,
                 o_ready, reset && !m_full);
    end
    if (o_underrun === 1'b1) ur_cnt++;
    if (o_sclk === 1'b1 && prev_sclk === 1'b0) begin
      if (o_lrck !== prev_lrck) sb = 0; else sb++;
      prev_lrck = o_lrck;
      if (sb >= 1 && sb <= DW) begin
        if (o_lrck) cur_r = {cur_r[DW-2:0], o_sd};
        else        cur_l = {cur_l[DW-2:0], o_sd};
      end else if (sb < SW && o_sd !== 1'b0) begin
        pad_err++;
      end
      if (sb == SW-1 && o_lrck === 1'b1) dec_q.push_back({cur_l, cur_r});
    end
    prev_sclk = o_sclk;
    if (!reset) begin
      cyc = 0; m_full = 1'b0; m_hold = '0; m_last = '0;
      exp_sclk = 1'b0; exp_lrck = 1'b1; exp_fs = 1'b0; exp_ur = 1'b0;
      exp_q.delete(); dec_q.delete();
      ur_cnt = 0; acc_cnt = 0; pad_err = 0;
      sb = 1000; prev_lrck = 1'b1; prev_sclk = 1'b0;
    end else begin
      logic acc;
      acc = i_valid && !m_full;
      if (i_valid && o_ready) acc_cnt++;
      cyc++;
      exp_sclk = ((cyc / SH) % 2) == 1;
      exp_fs = 1'b0; exp_ur = 1'b0;
      if (cyc % SCLK_P == 0) begin
        m = cyc / SCLK_P;
        bit_i = (m - 1) % (2*SW);
        exp_lrck = (bit_i >= SW);
        if (bit_i == 0) begin
          exp_fs = 1'b1;
          if (m_full) begin
            exp_q.push_back(m_hold); m_last = m_hold; m_full = 1'b0;
          end else begin
            exp_ur = 1'b1; exp_q.push_back(MUTE ? '0 : m_last);
          end
        end
      end
      if (acc) begin m_hold = {i_l_data, i_r_data}; m_full = 1'b1; end
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk); #1; reset = 1'b0; i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1; reset = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit keep_valid);
    bit ok = 1'b0;
    i_l_data = l; i_r_data = r; i_valid = 1'b1;
    for (int n = 0; n < 3*FRAME_P && !ok; n++) begin
      @(negedge clk);
      if (o_ready === 1'b1) ok = 1'b1;
    end
    @(posedge clk); #1;
    if (!keep_valid) i_valid = 1'b0;
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL send_timeout: got no o_ready, required accept"); end
  endtask

  task automatic wait_frames(input int n, input string name);
    int guard = 0;
    while (dec_q.size() < n && guard < (n+2)*FRAME_P) begin @(posedge clk); #1; guard++; end
    tests_run++;
    if (dec_q.size() < n) begin
      tests_failed++; $display("FAIL %s_frames: got %0d frames, required %0d", name, dec_q.size(), n);
    end
  endtask

  task automatic test_reset;
    int e0 = mon_err;
    @(posedge clk); #1; reset = 1'b0;
    i_valid = 1'b1; i_l_data = DW'($urandom); i_r_data = DW'($urandom);
    repeat (5) @(posedge clk);
    @(negedge clk);
    tests_run++; if (o_sclk !== 1'b0) begin tests_failed++; $display("FAIL reset_sclk: got %b required 0", o_sclk); end
    tests_run++; if (o_lrck !== 1'b1) begin tests_failed++; $display("FAIL reset_lrck: got %b required 1", o_lrck); end
    tests_run++; if (o_sd !== 1'b0) begin tests_failed++; $display("FAIL reset_sd: got %b required 0", o_sd); end
    tests_run++; if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b required 0", o_ready); end
    tests_run++; if (o_frame_start !== 1'b0 || o_underrun !== 1'b0) begin
      tests_failed++; $display("FAIL reset_pulses: got fs=%b ur=%b required 0 0", o_frame_start, o_underrun); end
    @(posedge clk); #1; reset = 1'b1; i_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL release_ready: got %b required 1", o_ready); end
    tests_run++; if (mon_err !== e0) begin tests_failed++; $display("FAIL reset_pins: got %0d pin errors required 0", mon_err - e0); end
  endtask

  task automatic test_single_pair;
    logic [2*DW-1:0] f, e;
    int e0 = mon_err;
    do_reset(3);
    send(24'hA55AC3, 24'h800001, 1'b0);
    wait_frames(1, "single");
    f = dec_q.pop_front(); e = exp_q.pop_front();
    tests_run++; if (f[2*DW-1:DW] !== 24'hA55AC3) begin tests_failed++; $display("FAIL single_left: got %h required a55ac3", f[2*DW-1:DW]); end
    tests_run++; if (f[DW-1:0] !== 24'h800001) begin tests_failed++; $display("FAIL single_right: got %h required 800001", f[DW-1:0]); end
    tests_run++; if (f !== e) begin tests_failed++; $display("FAIL single_model: got %h required %h", f, e); end
    tests_run++; if (pad_err !== 0) begin tests_failed++; $display("FAIL single_padding: got %0d nonzero pad bits required 0", pad_err); end
    tests_run++; if (ur_cnt !== 0) begin tests_failed++; $display("FAIL single_underrun: got %0d required 0", ur_cnt); end
    tests_run++; if (mon_err !== e0) begin tests_failed++; $display("FAIL single_pins: got %0d pin errors required 0", mon_err - e0); end
  endtask

  task automatic test_timing;
    int sclk_r[$], lrck_f[$], fs_t[$];
    logic pl = 1'b1, ps = 1'b0;
    do_reset(2);
    for (int i = 0; i < 2*FRAME_P + 50; i++) begin
      @(negedge clk);
      if (o_sclk === 1'b1 && ps === 1'b0) sclk_r.push_back(i);
      if (o_lrck === 1'b0 && pl === 1'b1) lrck_f.push_back(i);
      if (o_frame_start === 1'b1) fs_t.push_back(i);
      ps = o_sclk; pl = o_lrck;
    end
    tests_run++; if (sclk_r.size() < 2 || sclk_r[1] - sclk_r[0] !== SCLK_P) begin
      tests_failed++; $display("FAIL sclk_period: got %0d events required period %0d", sclk_r.size(), SCLK_P); end
    tests_run++; if (lrck_f.size() < 2 || lrck_f[1] - lrck_f[0] !== FRAME_P) begin
      tests_failed++; $display("FAIL lrck_period: got %0d events required period %0d", lrck_f.size(), FRAME_P); end
    tests_run++; if (fs_t.size() < 2 || fs_t[0] !== SCLK_P || fs_t[1] - fs_t[0] !== FRAME_P) begin
      tests_failed++; $display("FAIL frame_start_timing: got %0d pulses required first at %0d then every %0d", fs_t.size(), SCLK_P, FRAME_P); end
  endtask

  task automatic test_back_to_back;
    logic [2*DW-1:0] sent[7];
    logic [2*DW-1:0] f;
    int e0 = mon_err;
    do_reset(2);
    foreach (sent[i]) sent[i] = {DW'($urandom), DW'($urandom)};
    foreach (sent[i]) send(sent[i][2*DW-1:DW], sent[i][DW-1:0], 1'b1);
    wait_frames(6, "b2b");
    i_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      f = dec_q.pop_front();
      tests_run++; if (f !== sent[i]) begin tests_failed++; $display("FAIL b2b_frame%0d: got %h required %h", i, f, sent[i]); end
    end
    tests_run++; if (ur_cnt !== 0) begin tests_failed++; $display("FAIL b2b_underrun: got %0d required 0", ur_cnt); end
    tests_run++; if (acc_cnt !== 7) begin tests_failed++; $display("FAIL b2b_accepts: got %0d required 7", acc_cnt); end
    tests_run++; if (mon_err !== e0) begin tests_failed++; $display("FAIL b2b_pins: got %0d pin errors required 0", mon_err - e0); end
  endtask

  task automatic test_underrun;
    logic [DW-1:0] r = DW'($urandom);
    logic [2*DW-1:0] f1, f2, want2;
    int e0 = mon_err;
    do_reset(2);
    send(24'h123456, r, 1'b0);
    wait_frames(2, "underrun");
    f1 = dec_q.pop_front(); f2 = dec_q.pop_front();
    want2 = MUTE ? '0 : {24'h123456, r};
    tests_run++; if (f1 !== {24'h123456, r}) begin tests_failed++; $display("FAIL underrun_first: got %h required %h", f1, {24'h123456, r}); end
    tests_run++; if (f2 !== want2) begin tests_failed++; $display("FAIL underrun_repeat: got %h required %h", f2, want2); end
    tests_run++; if (ur_cnt !== 1) begin tests_failed++; $display("FAIL underrun_count: got %0d required 1", ur_cnt); end
    tests_run++; if (mon_err !== e0) begin tests_failed++; $display("FAIL underrun_pins: got %0d pin errors required 0", mon_err - e0); end
  endtask

  task automatic test_same_cycle;
    logic [2*DW-1:0] p = {DW'($urandom), DW'($urandom)};
    logic [2*DW-1:0] f2, f3;
    int guard = 0;
    do_reset(2);
    while (cyc != FRAME_P + SCLK_P - 1 && guard < 2*FRAME_P) begin @(posedge clk); #1; guard++; end
    i_l_data = p[2*DW-1:DW]; i_r_data = p[DW-1:0]; i_valid = 1'b1;
    @(posedge clk); #1; i_valid = 1'b0;
    tests_run++; if (o_underrun !== 1'b1 || o_frame_start !== 1'b1) begin
      tests_failed++; $display("FAIL same_cycle_flags: got ur=%b fs=%b required 1 1", o_underrun, o_frame_start); end
    tests_run++; if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL same_cycle_held: got ready %b required 0", o_ready); end
    wait_frames(3, "same_cycle");
    void'(dec_q.pop_front()); f2 = dec_q.pop_front(); f3 = dec_q.pop_front();
    tests_run++; if (f2 !== '0) begin tests_failed++; $display("FAIL same_cycle_frame2: got %h required 0", f2); end
    tests_run++; if (f3 !== p) begin tests_failed++; $display("FAIL same_cycle_frame3: got %h required %h", f3, p); end
    tests_run++; if (ur_cnt !== 2) begin tests_failed++; $display("FAIL same_cycle_underruns: got %0d required 2", ur_cnt); end
  endtask

  task automatic test_random;
    logic [2*DW-1:0] f, e;
    int e0 = mon_err;
    do_reset(2);
    while (cyc < 8*FRAME_P) begin
      repeat ($urandom_range(0, 700)) begin @(posedge clk); #1; end
      send(DW'($urandom), DW'($urandom), 1'b0);
    end
    wait_frames(8, "random");
    for (int i = 0; i < 8; i++) begin
      f = dec_q.pop_front(); e = exp_q.pop_front();
      tests_run++; if (f !== e) begin tests_failed++; $display("FAIL random_frame%0d: got %h required %h", i, f, e); end
    end
    tests_run++; if (pad_err !== 0) begin tests_failed++; $display("FAIL random_padding: got %0d required 0", pad_err); end
    tests_run++; if (mon_err !== e0) begin tests_failed++; $display("FAIL random_pins: got %0d pin errors required 0", mon_err - e0); end
  endtask

  task automatic test_reset_mid;
    int guard = 0, fs_at = -1;
    logic ur_at = 1'b0, lrck0 = 1'b0;
    do_reset(2);
    send(DW'($urandom), DW'($urandom), 1'b0);
    while (cyc < 200 && guard < FRAME_P) begin @(posedge clk); #1; guard++; end
    do_reset(1);
    for (int i = 0; i < 3*SCLK_P; i++) begin
      @(negedge clk);
      if (i == 0) lrck0 = o_lrck;
      if (o_frame_start === 1'b1 && fs_at < 0) begin fs_at = i; ur_at = o_underrun; end
    end
    tests_run++; if (lrck0 !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_lrck: got %b required 1", lrck0); end
    tests_run++; if (fs_at !== SCLK_P) begin tests_failed++; $display("FAIL mid_reset_first_frame: got %0d required %0d", fs_at, SCLK_P); end
    tests_run++; if (ur_at !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_underrun: got %b required 1", ur_at); end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_timing();
    test_back_to_back();
    test_underrun();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
